// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------------------------------------------------------------------
// Purpose: parametrised valid/ready pipeline register between two stages
// (e.g. idecode -> execute). A 2-entry skid buffer (main + skid) keeps
// in_ready driven straight from a flop, so the upstream stage never sees a
// combinational path from out_ready. A synchronous flush squashes everything
// held, and an empty stage can present a nop payload (RESET_VAL).
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept (registered, 0 only when both entries full)
//   in_data    in   upstream payload [DATA_W-1:0]
//   out_valid  out  main entry holds a valid payload
//   out_ready  in   downstream accepts this cycle
//   out_data   out  main entry payload [DATA_W-1:0]
//   flush      in   synchronous squash of all held entries
//   count      out  number of valid entries held (0..2)
//
// Optional statistics (define PIPE_STAGE_STAT_EN):
//   clr_stat   in   synchronous clear of both counters
//   stall_cnt  out  cycles with out_valid=1 and out_ready=0 (saturating)
//   bubble_cnt out  cycles with out_valid=0 and out_ready=1 (saturating)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned          DATA_W         = 32,
  parameter logic [DATA_W-1:0]    RESET_VAL      = {DATA_W{1'b0}},
  parameter bit                   CLEAR_ON_EMPTY = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
`ifdef PIPE_STAGE_STAT_EN
  input  logic              clr_stat,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
`endif
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [1:0]          r_count;

  logic                w_accept;
  logic                w_pop;
  logic [DATA_W-1:0]   w_empty_val;

  // Handshake decode and the value main takes when the stage drains.
  always_comb begin
    w_accept    = in_valid & r_in_ready;
    w_pop       = r_out_valid & out_ready;
    w_empty_val = r_main;
    if (CLEAR_ON_EMPTY) begin
      w_empty_val = RESET_VAL;
    end else begin
      w_empty_val = r_main;
    end
  end

  // Skid-buffer FSM; in_ready/out_valid/count are flops updated with the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_EMPTY;
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= 2'd0;
    end else if (flush) begin
      // Squash: any same-cycle accept or pop is dropped.
      r_state     <= ST_EMPTY;
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_HALF;
            r_main      <= in_data;
            r_out_valid <= 1'b1;
            r_count     <= 2'd1;
          end else begin
            r_state     <= ST_EMPTY;
          end
        end
        ST_HALF: begin
          if (w_accept && w_pop) begin
            r_main      <= in_data;
          end else if (w_accept) begin
            // Downstream stalled: park the new item behind main.
            r_state     <= ST_FULL;
            r_skid      <= in_data;
            r_in_ready  <= 1'b0;
            r_count     <= 2'd2;
          end else if (w_pop) begin
            r_state     <= ST_EMPTY;
            r_main      <= w_empty_val;
            r_out_valid <= 1'b0;
            r_count     <= 2'd0;
          end else begin
            r_state     <= ST_HALF;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no accept can occur.
          if (w_pop) begin
            r_state     <= ST_HALF;
            r_main      <= r_skid;
            r_in_ready  <= 1'b1;
            r_count     <= 2'd1;
          end else begin
            r_state     <= ST_FULL;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_main      <= RESET_VAL;
          r_skid      <= RESET_VAL;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_count     <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign count     = r_count;

`ifdef PIPE_STAGE_STAT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Saturating stall/bubble counters; flush leaves them alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else if (clr_stat) begin
      r_stall_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (!r_out_valid && out_ready && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: a directed vector table, hand-written
// reset/stat sequences and a randomized run against a queue model.
// Two instances share stimulus: one with CLEAR_ON_EMPTY=1, one with 0.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        in_ready,  in_ready0;
  logic        out_valid, out_valid0;
  logic [31:0] out_data,  out_data0;
  logic [1:0]  count,     count0;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PIPE_STAGE_STAT_EN
  logic        clr_stat;
  logic [31:0] stall_cnt,  stall_cnt0;
  logic [31:0] bubble_cnt, bubble_cnt0;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .CLEAR_ON_EMPTY(1'b1)) u_dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush),
`ifdef PIPE_STAGE_STAT_EN
    .clr_stat(clr_stat), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .count(count)
  );

  pipe_stage_skid #(.DATA_W(32), .CLEAR_ON_EMPTY(1'b0)) u_dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .flush(flush),
`ifdef PIPE_STAGE_STAT_EN
    .clr_stat(clr_stat), .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0),
`endif
    .count(count0)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic        er;
    logic [1:0]  ec;
    logic [31:0] ed;
    logic [31:0] ed0;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic er,
                         input logic [1:0] ec, input logic [31:0] ed, input logic [31:0] ed0);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, er});
    chk({tag, ".count"},     {30'd0, count},     {30'd0, ec});
    chk({tag, ".out_data"},  out_data,           ed);
    chk({tag, ".out_valid0"},{31'd0, out_valid0},{31'd0, ev});
    chk({tag, ".out_data0"}, out_data0,          ed0);
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an in-order queue of at most two items.
  logic [31:0] mq[$];
  logic [31:0] m_hold0;

  task automatic model_step();
    logic acc;
    logic pp;
    acc = in_valid && (mq.size() < 2);
    pp  = (mq.size() > 0) && out_ready;
    if (flush) begin
      mq.delete();
      m_hold0 = 32'd0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      if (mq.size() > 0) m_hold0 = mq[0];
    end
  endtask

  initial begin
    // Directed table: inputs applied before an edge, outputs expected after it.
    //            iv    d        ordy  fl    ev    er    ec     ed       ed0
    tv[0]  = '{1'b1, 32'h1,   1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h1,  32'h1};
    tv[1]  = '{1'b1, 32'h2,   1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h2,  32'h2};
    tv[2]  = '{1'b1, 32'h3,   1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h3,  32'h3};
    tv[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  32'h3};
    tv[4]  = '{1'b1, 32'hA,   1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA,  32'hA};
    tv[5]  = '{1'b1, 32'hB,   1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA,  32'hA};
    tv[6]  = '{1'b1, 32'hE,   1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA,  32'hA};
    tv[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hB,  32'hB};
    tv[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  32'hB};
    tv[9]  = '{1'b1, 32'hA,   1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA,  32'hA};
    tv[10] = '{1'b1, 32'hB,   1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA,  32'hA};
    tv[11] = '{1'b1, 32'hC,   1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,  32'h0};
    tv[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  32'h0};
    tv[13] = '{1'b1, 32'h55,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h55, 32'h55};
    tv[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  32'h55};
    tv[15] = '{1'b1, 32'h7,   1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h7,  32'h7};
    tv[16] = '{1'b1, 32'h8,   1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,  32'h0};
    tv[17] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  32'h0};

    drive(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_STAT_EN
    clr_stat = 1'b0;
`endif
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1 chk_all("reset0", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].iv, tv[i].d, tv[i].ordy, tv[i].fl);
      tick();
      chk_all($sformatf("vec%0d", i), tv[i].ev, tv[i].er, tv[i].ec, tv[i].ed, tv[i].ed0);
    end

    // Fill to FULL, then pulse resetn between clock edges.
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    tick();
    chk_all("prefull", 1'b1, 1'b0, 2'd2, 32'hA, 32'hA);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1 chk_all("midreset", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    #1 resetn = 1'b1;

    // Flush while resetn is low: reset values hold.
    @(negedge clk);
    drive(1'b1, 32'h99, 1'b1, 1'b1);
    resetn = 1'b0;
    tick();
    chk_all("flush_in_reset", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Randomized run against the queue model (both instances start empty).
    mq.delete();
    m_hold0 = 32'd0;
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
      @(posedge clk);
      model_step();
      #1;
      chk_all($sformatf("rnd%0d", c), 1'(mq.size() > 0), 1'(mq.size() < 2),
              2'(mq.size()), (mq.size() > 0) ? mq[0] : 32'h0,
              (mq.size() > 0) ? mq[0] : m_hold0);
    end

`ifdef PIPE_STAGE_STAT_EN
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("stat_clr0.stall", stall_cnt, 32'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("stat.stall5", stall_cnt, 32'd5);
    chk("stat.bubble0", bubble_cnt, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1 == 1'b0);
    tick();
    tick();
    chk("stat.drained", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) tick();
    chk("stat.bubble3", bubble_cnt, 32'd3);
    chk("stat.stall_keep", stall_cnt, 32'd5);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("stat.clr_stall", stall_cnt, 32'd0);
    chk("stat.clr_bubble", bubble_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
